cla_iter_adder: RTL and testbench
=================================

Name: cla_iter_adder

Overview:
- Multi-cycle wide adder/subtractor that consumes a registered group carry.
- Each cycle it resolves one 4-bit group using carry-lookahead: p/g per bit, intra-group carries c1..c3, group sum and group carry-out.
- The group carry-out is registered and fed in as the carry-in of the next group on the following cycle.
- It sits beside the combinational CLA blocks as the area-lean, operand-width-scalable datapath, with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of 4 and at least 4.
- NG, WIDTH/4, number of 4-bit groups (derived, not overridden); equals the latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- op_sub  input  1  0: a+b+cin; 1: a-b (b inverted, carry-in forced to 1, cin ignored).
- cin  input  1  carry-in for addition.
- a  input  WIDTH  operand A, latched on accept.
- b  input  WIDTH  operand B, latched on accept.
- sum  output  WIDTH  result, held stable between completions.
- cout  output  1  carry out of the MSB group (for subtraction, 1 = no borrow).
- overflow  output  1  signed overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- busy  output  1  high while groups are being processed.
- done  output  1  one-cycle pulse when sum/cout/overflow update.

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE.
  - busy, done, cout, overflow, sum, group index and carry register all 0.
  - Latched operands are cleared; any in-flight operation is discarded, with no done pulse.
- States: IDLE, RUN, DONE.
- Accept: at edge E0 with start=1 and busy=0 (state IDLE or DONE):
  - latch a, b (inverted if op_sub), and carry register = op_sub ? 1 : cin;
  - group index k=0; state->RUN; busy=1 after E0.
- RUN, at each edge Ek+1 (k = 0..NG-1):
  - Process group k, bits [4k+3:4k], with the carry register as c0.
  - Per bit: p=a^b, g=a&b.
  - c1=g0|p0c0; c2=g1|p1c1; c3=g2|p2c2; cg=g3|p3c3.
  - Sum bits s=p^c, written into the internal result register.
  - Carry register <= cg; k <= k+1.
  - For k=NG-1, also capture c3 (carry into the MSB) for overflow.
- Completion at edge E_NG:
  - sum <= full internal result; cout <= cg; overflow <= c3^cg.
  - done=1, busy=0, state->DONE.
  - Latency is exactly NG cycles from the accept edge to the outputs valid.
- DONE lasts one cycle, after which the next edge moves the block to IDLE and done returns to 0.
  - If start=1 at that edge, the block accepts instead (back-to-back): state->RUN, done->0, busy->1.
  - Throughput is therefore one result per NG+1 cycles.
- start while busy=1 is ignored entirely: no re-latch, no effect on the result.
- Input changes on a, b, cin and op_sub after the accept edge have no effect on the operation in flight.
- sum, cout and overflow change only at completion edges (and reset). They hold the last result through IDLE and through the next RUN.
- Wrap-around: the result is modulo 2^WIDTH; the carry out of the MSB goes to cout only.
- NG=1 (WIDTH=4): RUN lasts one cycle; done is asserted after the first edge following accept.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0, op_sub=0 -> after 4 cycles done=1 for one cycle; sum=0x0000, cout=1, overflow=0; busy high for exactly 4 cycles.
- WIDTH=16, op_sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, overflow=0; repeat with a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- WIDTH=16, a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, overflow=1, cout=0; also a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
- Start pulses with new operands during cycles 2 and 3 of a busy operation -> ignored; result matches the first operands; no extra done pulse.
- rst asserted asynchronously mid-RUN (cycle 2) -> busy, done, sum, cout and overflow go to 0 immediately without a clock edge; no done pulse; the next start computes correctly.
- Back-to-back: start held high across the done cycle with new operands -> second operation accepted on the DONE edge; two done pulses 5 cycles apart; both sums correct.

Source files
------------

// File: rtl/cla_iter_adder_if.sv
`default_nettype none
// ============================================================================
// Module : cla_iter_adder_if
// Brief  : Request/result bundle for the iterative group-CLA adder.
// Rev    : 1.0
// ============================================================================
interface cla_iter_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, op_sub, cin, a, b,
    input  sum, cout, overflow, busy, done
  );

  modport slave (
    input  start, op_sub, cin, a, b,
    output sum, cout, overflow, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/cla_iter_adder.sv
`default_nettype none
// ============================================================================
// Module : cla_iter_adder
// Brief  : Multi-cycle add/sub resolving one 4-bit CLA group per clock.
// Rev    : 1.0
// ============================================================================
module cla_iter_adder #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       rst,
  cla_iter_adder_if.slave bus
);
  localparam int NG = WIDTH / 4;
  localparam int KW = (NG > 1) ? $clog2(NG) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  logic [BW-1:0]    base;
  logic [3:0]       ga, gb, gp, gg, gs;
  logic             c1, c2, c3, cg;
  logic             last;
  logic             accept;

  // One 4-bit lookahead group, selected by the group index
  always_comb begin
    base = BW'({k_q, 2'b00});
    ga   = a_q[base +: 4];
    gb   = b_q[base +: 4];
    gp   = ga ^ gb;
    gg   = ga & gb;
    c1   = gg[0] | (gp[0] & carry_q);
    c2   = gg[1] | (gp[1] & c1);
    c3   = gg[2] | (gp[2] & c2);
    cg   = gg[3] | (gp[3] & c3);
    gs   = gp ^ {c3, c2, c1, carry_q};
    last = (k_q == KW'(NG - 1));
  end

  assign accept = (state_q != ST_RUN) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      sum_q      <= '0;
      k_q        <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      sum_q      <= sum_d;
      k_q        <= k_d;
      carry_q    <= carry_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: if (accept) state_d = ST_RUN;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    sum_d      = sum_q;
    k_d        = k_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    if (state_q == ST_RUN) begin
      res_d[base +: 4] = gs;
      carry_d          = cg;
      k_d              = last ? '0 : k_q + 1'b1;
      // The final group also publishes the full result and flags
      if (last) begin
        sum_d      = res_d;
        cout_d     = cg;
        overflow_d = c3 ^ cg;
      end
    end else if (accept) begin
      a_d     = bus.a;
      b_d     = bus.op_sub ? ~bus.b : bus.b;
      carry_d = bus.op_sub | bus.cin;
      k_d     = '0;
    end
  end

  always_comb begin
    bus.busy     = (state_q == ST_RUN);
    bus.done     = (state_q == ST_DONE);
    bus.sum      = sum_q;
    bus.cout     = cout_q;
    bus.overflow = overflow_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_cla_iter_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_cla_iter_adder
// Brief  : Directed-vector bench for cla_iter_adder (WIDTH=16 and WIDTH=4).
// Rev    : 1.0
// ============================================================================
module tb_cla_iter_adder;
  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  cla_iter_adder_if #(.WIDTH(16)) bus ();
  cla_iter_adder_if #(.WIDTH(4))  bus4 ();

  cla_iter_adder #(.WIDTH(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  cla_iter_adder #(.WIDTH(4))  dut_4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sub, output int lat, output int bcnt);
    bus.a = a; bus.b = b; bus.cin = ci; bus.op_sub = sub; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0; bcnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      tick();
      lat++;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {bus.cout, bus.overflow}); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_add_wrap();
    int lat, bcnt;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcnt);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL wrap_latency: got %0d want 4", lat); end
    n_vec++; if (bcnt !== 4) begin n_err++; $display("FAIL wrap_busy_cycles: got %0d want 4", bcnt); end
    n_vec++; if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL wrap_sum: got %h want 0000", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b10) begin n_err++; $display("FAIL wrap_flags: got %b want 10", {bus.cout, bus.overflow}); end
    tick();
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL wrap_done_width: got %b want 0", bus.done); end
    n_vec++; if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL wrap_sum_hold: got %h want 0000", bus.sum); end
  endtask

  task automatic test_sub();
    int lat, bcnt;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, bcnt);
    n_vec++; if (bus.sum !== 16'hFFFE) begin n_err++; $display("FAIL sub_neg_sum: got %h want fffe", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b00) begin n_err++; $display("FAIL sub_neg_flags: got %b want 00", {bus.cout, bus.overflow}); end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, bcnt);
    n_vec++; if (bus.sum !== 16'h7FFF) begin n_err++; $display("FAIL sub_ovf_sum: got %h want 7fff", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b11) begin n_err++; $display("FAIL sub_ovf_flags: got %b want 11", {bus.cout, bus.overflow}); end
    // cin must be ignored when subtracting
    run_op(16'h0010, 16'h0001, 1'b1, 1'b1, lat, bcnt);
    n_vec++; if (bus.sum !== 16'h000F) begin n_err++; $display("FAIL sub_cin_sum: got %h want 000f", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b10) begin n_err++; $display("FAIL sub_cin_flags: got %b want 10", {bus.cout, bus.overflow}); end
  endtask

  task automatic test_add_ovf();
    int lat, bcnt;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bcnt);
    n_vec++; if (bus.sum !== 16'h8000) begin n_err++; $display("FAIL add_ovf_sum: got %h want 8000", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b01) begin n_err++; $display("FAIL add_ovf_flags: got %b want 01", {bus.cout, bus.overflow}); end
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat, bcnt);
    n_vec++; if (bus.sum !== 16'h5556) begin n_err++; $display("FAIL add_cin_sum: got %h want 5556", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b00) begin n_err++; $display("FAIL add_cin_flags: got %b want 00", {bus.cout, bus.overflow}); end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    tick();
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.op_sub = 1'b0; bus.start = 1'b1;
    tick();                                   // E0: accept
    bus.start = 1'b0;
    tick();                                   // E1
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.op_sub = 1'b1; bus.cin = 1'b1; bus.start = 1'b1;
    tick();                                   // E2
    bus.a = 16'hABCD; bus.b = 16'h0F0F;
    tick();                                   // E3
    bus.start = 1'b0;
    tick();                                   // E4: completion
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL ignore_done: got %b want 1", bus.done); end
    n_vec++; if (bus.sum !== 16'h3333) begin n_err++; $display("FAIL ignore_sum: got %h want 3333", bus.sum); end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL ignore_extra_activity: got %0d want 0", dones); end
  endtask

  task automatic test_async_reset();
    int lat, bcnt;
    int act = 0;
    run_op(16'h8000, 16'h8001, 1'b0, 1'b0, lat, bcnt);
    n_vec++; if (bus.sum !== 16'h0001) begin n_err++; $display("FAIL pre_reset_sum: got %h want 0001", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b11) begin n_err++; $display("FAIL pre_reset_flags: got %b want 11", {bus.cout, bus.overflow}); end
    tick();
    bus.a = 16'h0001; bus.b = 16'h0001; bus.op_sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    tick();                                   // E0
    bus.start = 1'b0;
    tick();                                   // E1, now in cycle 2
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({bus.busy, bus.done} !== 2'b00) begin n_err++; $display("FAIL arst_busy_done: got %b want 00", {bus.busy, bus.done}); end
    n_vec++; if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL arst_sum: got %h want 0000", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b00) begin n_err++; $display("FAIL arst_flags: got %b want 00", {bus.cout, bus.overflow}); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.busy) act++;
    end
    n_vec++; if (act !== 0) begin n_err++; $display("FAIL arst_no_done: got %0d want 0", act); end
    run_op(16'h00FF, 16'h0101, 1'b0, 1'b0, lat, bcnt);
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL post_reset_latency: got %0d want 4", lat); end
    n_vec++; if (bus.sum !== 16'h0200) begin n_err++; $display("FAIL post_reset_sum: got %h want 0200", bus.sum); end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1, n;
    tick();
    bus.a = 16'h0102; bus.b = 16'h0304; bus.cin = 1'b0; bus.op_sub = 1'b0; bus.start = 1'b1;
    tick();                                   // first accept
    bus.a = 16'hA000; bus.b = 16'h1000; bus.op_sub = 1'b1;
    n = 0;
    while (!bus.done && n < 20) begin tick(); n++; end
    if (bus.done) t1 = cyc;
    n_vec++; if (bus.sum !== 16'h0406) begin n_err++; $display("FAIL b2b_first_sum: got %h want 0406", bus.sum); end
    tick();                                   // DONE edge doubles as second accept
    n_vec++; if ({bus.busy, bus.done} !== 2'b10) begin n_err++; $display("FAIL b2b_accept: got busy,done=%b want 10", {bus.busy, bus.done}); end
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin tick(); n++; end
    if (bus.done) t2 = cyc;
    n_vec++; if (t2 - t1 !== 5 || t1 < 0) begin n_err++; $display("FAIL b2b_spacing: got %0d want 5", t2 - t1); end
    n_vec++; if (bus.sum !== 16'h9000) begin n_err++; $display("FAIL b2b_second_sum: got %h want 9000", bus.sum); end
    n_vec++; if ({bus.cout, bus.overflow} !== 2'b10) begin n_err++; $display("FAIL b2b_second_flags: got %b want 10", {bus.cout, bus.overflow}); end
    tick();
  endtask

  task automatic test_single_group();
    bus4.a = 4'hF; bus4.b = 4'h1; bus4.cin = 1'b0; bus4.op_sub = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    n_vec++; if ({bus4.busy, bus4.done} !== 2'b10) begin n_err++; $display("FAIL ng1_run: got busy,done=%b want 10", {bus4.busy, bus4.done}); end
    tick();
    n_vec++; if (bus4.done !== 1'b1) begin n_err++; $display("FAIL ng1_done: got %b want 1", bus4.done); end
    n_vec++; if ({bus4.cout, bus4.overflow, bus4.sum} !== 6'b10_0000) begin n_err++; $display("FAIL ng1_wrap: got %b want 100000", {bus4.cout, bus4.overflow, bus4.sum}); end
    bus4.a = 4'h7; bus4.b = 4'h1; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    n_vec++; if ({bus4.cout, bus4.overflow, bus4.sum} !== 6'b01_1000) begin n_err++; $display("FAIL ng1_ovf: got %b want 011000", {bus4.cout, bus4.overflow, bus4.sum}); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    bus4.start = 1'b0; bus4.op_sub = 1'b0; bus4.cin = 1'b0; bus4.a = '0; bus4.b = '0;
    test_reset();
    test_add_wrap();
    test_sub();
    test_add_ovf();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_single_group();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
